// File: rtl/mips_div_pkg.sv
// mips_div_pkg
// Shared definitions for the MIPS multi-cycle divider: FSM state encoding,
// iteration count, the divide-by-zero quotient constant and a small
// two's-complement helper used when forming magnitudes and signed results.
package mips_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  localparam int          DIV_ITERS     = 32;
  localparam int          CNT_W         = 6;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // Conditionally negate a 32-bit value (two's complement).
  function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mips_divider_sub.sv
// _32bit_sub
// 32-bit subtractor cell: diff = a + ~b + cin, cout is the carry out.
// With cin = 1 this is a - b, and cout = 1 means no borrow (a >= b).
// Ports:
//   a, b  : 32-bit operands
//   cin   : carry in (1 for a true subtraction)
//   diff  : 32-bit result
//   cout  : carry out
module _32bit_sub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] diff,
  output logic        cout
);

  logic [32:0] sum;

  assign sum  = {1'b0, a} + {1'b0, ~b} + {32'd0, cin};
  assign diff = sum[31:0];
  assign cout = sum[32];

endmodule

// File: rtl/mips_divider.sv
// mips_divider
// Multi-cycle 32-bit DIV/DIVU for the MIPS EX stage. Restoring shift-subtract,
// one quotient bit per cycle on operand magnitudes, with sign fix-up at the end.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request a division (accepted only when idle)
//   is_signed    : 1 = DIV (two's complement), 0 = DIVU
//   dividend     : numerator
//   divisor      : denominator
//   busy         : high from the cycle after an accepted start through done
//   done         : one-cycle pulse, results valid from this cycle on
//   div_by_zero  : last operation had a zero divisor
//   quotient     : LO result
//   remainder    : HI result
module mips_divider
  import mips_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [32:0]      prem_reg, prem_next;   // partial remainder
  logic [31:0]      pquo_reg, pquo_next;   // dividend magnitude, becomes quotient
  logic [31:0]      dvsr_reg, dvsr_next;   // divisor magnitude
  logic             q_neg_reg, q_neg_next;
  logic             r_neg_reg, r_neg_next;
  logic [31:0]      quotient_reg, quotient_next;
  logic [31:0]      remainder_reg, remainder_next;
  logic             dz_reg, dz_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  // One iteration: shift {partial remainder, dividend} left and trial-subtract.
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        cout;
  logic        no_borrow;

  assign shifted = {prem_reg[31:0], pquo_reg[31]};

  _32bit_sub u_sub (
    .a    (shifted[31:0]),
    .b    (dvsr_reg),
    .cin  (1'b1),
    .diff (diff),
    .cout (cout)
  );

  // The shifted-out bit 32 means the 33-bit value certainly exceeds the
  // 32-bit divisor even when the low-word subtract borrows. prem_reg[32] is
  // always 0 between iterations (remainder < divisor) but is kept in the term
  // so the full 33-bit partial remainder participates.
  assign no_borrow = cout | shifted[32] | prem_reg[32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      prem_reg      <= '0;
      pquo_reg      <= '0;
      dvsr_reg      <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dz_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      prem_reg      <= prem_next;
      pquo_reg      <= pquo_next;
      dvsr_reg      <= dvsr_next;
      q_neg_reg     <= q_neg_next;
      r_neg_reg     <= r_neg_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dz_reg        <= dz_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    prem_next      = prem_reg;
    pquo_next      = pquo_reg;
    dvsr_next      = dvsr_reg;
    q_neg_next     = q_neg_reg;
    r_neg_next     = r_neg_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dz_next        = dz_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          q_neg_next = is_signed & (dividend[31] ^ divisor[31]);
          r_neg_next = is_signed & dividend[31];
          pquo_next  = cond_neg(is_signed & dividend[31], dividend);
          dvsr_next  = cond_neg(is_signed & divisor[31], divisor);
          cnt_next   = '0;
          prem_next  = '0;
          if (divisor == 32'd0) begin
            // Zero divisor: results are known immediately, skip the iterations.
            quotient_next  = DIV_ZERO_QUOT;
            remainder_next = dividend;
            dz_next        = 1'b1;
            state_next     = ST_DONE;
          end else begin
            state_next = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        prem_next = no_borrow ? {1'b0, diff} : shifted;
        pquo_next = {pquo_reg[30:0], no_borrow};
        cnt_next  = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(DIV_ITERS - 1)) begin
          state_next = ST_FIX;
        end
      end

      ST_FIX: begin
        // Output registers only change here (or on a zero divisor), so the
        // previous result holds throughout a running operation.
        quotient_next  = cond_neg(q_neg_reg, pquo_reg);
        remainder_next = cond_neg(r_neg_reg, prem_reg[31:0]);
        dz_next        = 1'b0;
        state_next     = ST_DONE;
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Status outputs are registered views of the state being entered.
    busy_next = (state_next != ST_IDLE);
    done_next = (state_next == ST_DONE);
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign div_by_zero = dz_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;

endmodule

// File: tb/tb_mips_divider.sv
// tb_mips_divider
// Directed bench for mips_divider. A per-cycle compare process checks busy,
// done and the held results against an arithmetic reference model and a
// cycle-count expectation; literal checks after each directed operation
// pin the model's values.
module tb_mips_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks   = 0;
  int failures = 0;

  mips_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_edge = 0;
  always @(posedge clk) n_edge <= n_edge + 1;

  // Scoreboard shared between the driver and the compare process.
  logic        active   = 1'b0;
  int          launch_e = 0;
  int          lat      = 0;
  logic [31:0] pend_q   = '0;
  logic [31:0] pend_r   = '0;
  logic        pend_dz  = 1'b0;
  logic [31:0] held_q   = '0;
  logic [31:0] held_r   = '0;
  logic        held_dz  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model straight from the arithmetic definition of DIV/DIVU.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    int sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (!s) begin
      q = a / b; r = a % b; dz = 1'b0;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; dz = 1'b0;
    end else begin
      sa = $signed(a); sb = $signed(b);
      q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0;
    end
  endtask

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    int  rel;
    logic exp_busy, exp_done;
    if (!rst_n) begin
      active  = 1'b0;
      held_q  = '0;
      held_r  = '0;
      held_dz = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dz",   {31'd0, div_by_zero}, 32'd0);
      chk("rst_quot", quotient, 32'd0);
      chk("rst_rem",  remainder, 32'd0);
    end else begin
      rel      = n_edge - launch_e + 1;
      exp_busy = active && rel >= 1 && rel <= lat;
      exp_done = active && rel == lat;
      if (exp_done) begin
        held_q  = pend_q;
        held_r  = pend_r;
        held_dz = pend_dz;
      end
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, held_dz});
      chk("quotient", quotient, held_q);
      chk("remainder", remainder, held_r);
      if (exp_done) active = 1'b0;
    end
  end

  // All driver tasks run at negedge + 1.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    model(s, a, b, pend_q, pend_r, pend_dz);
    lat       = (b == 32'd0) ? 1 : 34;
    launch_e  = n_edge + 1;
    active    = 1'b1;
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    $display("op: signed=%0d %h / %h -> expect q=%h r=%h dz=%0d", s, a, b, pend_q, pend_r, pend_dz);
    @(negedge clk); #1;
    start     = 1'b0;
    is_signed = 1'($urandom_range(0, 1));
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  task automatic goto_rel(input int k);
    int guard = 0;
    while (n_edge - launch_e + 1 < k) begin
      @(negedge clk); #1;
      guard++;
      if (guard > 200) begin
        chk("goto_rel_timeout", 32'(guard), 32'd200);
        break;
      end
    end
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    launch(s, a, b);
    goto_rel((b == 32'd0) ? 2 : 35);
  endtask

  task automatic lit(input string name, input logic [31:0] q, input logic [31:0] r, input logic dz);
    chk({name, "_q"}, quotient, q);
    chk({name, "_r"}, remainder, r);
    chk({name, "_dz"}, {31'd0, div_by_zero}, {31'd0, dz});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;

    // 100 / 7 with ignored start pulses in cycle 10 and in the DONE cycle.
    launch(1'b0, 32'd100, 32'd7);
    goto_rel(10);
    start = 1'b1; is_signed = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk); #1;
    start = 1'b0;
    goto_rel(34);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd0;
    @(negedge clk); #1;
    start = 1'b0;
    lit("u100_7", 32'd14, 32'd2, 1'b0);

    // Back-to-back: launched in the first IDLE cycle.
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    lit("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 32'h1234_5678, 32'd0);
    lit("dz_u", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    lit("s_ovf", 32'h8000_0000, 32'd0, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    lit("u_max_1", 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    lit("s_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD);
    lit("s_m8_m3", 32'd2, 32'hFFFF_FFFE, 1'b0);
    run_op(1'b1, 32'h8000_0001, 32'd0);
    lit("dz_s", 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10);
    run_op(1'b0, 32'd3, 32'd7);
    run_op(1'b1, 32'h8000_0000, 32'd1);

    // Reset in cycle 15 of a running operation.
    launch(1'b0, 32'd100, 32'd7);
    goto_rel(15);
    rst_n = 1'b0;
    #1;
    lit("rst_mid", 32'd0, 32'd0, 1'b0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    run_op(1'b0, 32'd9, 32'd3);
    lit("u9_3", 32'd3, 32'd0, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
